// File: rtl/serial_subtractor_if.sv
// Bundle of launch/result signals between a controlling FSM and serial_subtractor.
// Latency: none, wires only.
// Backpressure: none; start is simply ignored by the subtractor while it is busy.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    // Controller side: launches operations, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Latency: WIDTH+1 edges from accept to done; issue interval WIDTH+2 cycles.
// Backpressure: start accepted only in IDLE, dropped (not queued) while busy/done.
// Optional signed overflow flag built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_diff;
    logic             cell_borrow;

    // Full-subtractor on the current operand LSBs and the carried-in borrow.
    always_comb begin
        cell_diff   = sa_q[0] ^ sb_q[0] ^ br_q;
        cell_borrow = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    // Next-state and datapath: load on accept, shift one bit per SHIFT edge.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sd_d  = {cell_diff, sd_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                br_d  = cell_borrow;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = sd_q;
    assign bus.borrow_out = br_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;

    // Operand MSBs sit in the LSB slots on the last SHIFT edge; clear on accept
    // so the flag reads 0 until a fresh result is complete.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (state_q == IDLE && bus.start) begin
            a_msb_d = 1'b0;
            b_msb_d = 1'b0;
        end else if (state_q == SHIFT && cnt_q == LAST) begin
            a_msb_d = sa_q[0];
            b_msb_d = sb_q[0];
        end
    end

    // Captured operand sign bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from a.
    assign bus.overflow = (a_msb_q ^ b_msb_q) & (sd_q[WIDTH-1] ^ a_msb_q);
`else
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8.
// Drives and samples 1 ns after each rising edge.
// Expected values are hand-computed constants.
module tb_serial_subtractor;
    localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h want=00", bus.diff); end
        checks++; if (bus.borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b want=0", bus.borrow_out); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    // One operation: accept, then wait a bounded time for done.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_diff, input logic exp_bo, input logic exp_ovf);
        int n;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();                          // accept edge E
        bus.start = 1'b0;
        bus.a     = ~a;                  // operands may change after accept
        bus.b     = ~b;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s_busy_after_accept got=%b want=1", name, bus.busy); end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== WIDTH) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", name, n, WIDTH); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_busy_in_done got=%b want=0", name, bus.busy); end
        checks++; if (bus.diff !== exp_diff) begin failures++; $display("FAIL %s_diff got=%h want=%h", name, bus.diff, exp_diff); end
        checks++; if (bus.borrow_out !== exp_bo) begin failures++; $display("FAIL %s_borrow got=%b want=%b", name, bus.borrow_out, exp_bo); end
        checks++; if (bus.overflow !== exp_ovf) begin failures++; $display("FAIL %s_ovf got=%b want=%b", name, bus.overflow, exp_ovf); end
        tick();                          // back in IDLE, result holds
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b want=0", name, bus.done); end
        checks++; if (bus.diff !== exp_diff) begin failures++; $display("FAIL %s_diff_hold got=%h want=%h", name, bus.diff, exp_diff); end
    endtask

    task automatic test_basic();
        run_op("sub100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        run_op("sub5_9", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
        run_op("sub80_01", 8'h80, 8'h01, 8'h7F, 1'b0, OVF_EN);
    endtask

    task automatic test_ignore_start();
        int dones;
        dones     = 0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                bus.a     = 8'hFF;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done === 1'b1) begin
                dones++;
                checks++; if (bus.diff !== 8'h00) begin failures++; $display("FAIL ignore_diff got=%h want=00", bus.diff); end
                checks++; if (bus.borrow_out !== 1'b0) begin failures++; $display("FAIL ignore_borrow got=%b want=0", bus.borrow_out); end
            end
        end
        bus.start = 1'b0;
        checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_reset_mid_shift();
        int dones;
        dones     = 0;
        bus.a     = 8'd100;
        bus.b     = 8'd37;
        bus.start = 1'b1;
        tick();                          // accept edge
        bus.start = 1'b0;
        tick(); tick(); tick();          // SHIFT edges 1..3
        rst_n = 1'b0;
        tick();                          // 4th SHIFT edge, reset applied
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
        checks++; if (bus.diff !== 8'h00) begin failures++; $display("FAIL rstmid_diff got=%h want=00", bus.diff); end
        checks++; if (bus.borrow_out !== 1'b0) begin failures++; $display("FAIL rstmid_borrow got=%b want=0", bus.borrow_out); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b want=0", bus.overflow); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int last;
        dones     = 0;
        last      = -1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (bus.busy === 1'b1 && bus.done === 1'b1) begin failures++; $display("FAIL b2b_overlap cycle=%0d busy=1 done=1 want not both", i); end
            if (bus.done === 1'b1) begin
                dones++;
                checks++; if (bus.diff !== 8'h0F) begin failures++; $display("FAIL b2b_diff got=%h want=0F", bus.diff); end
                if (last >= 0) begin
                    checks++; if (i - last !== 10) begin failures++; $display("FAIL b2b_interval got=%0d want=10", i - last); end
                end
                last = i;
            end
        end
        bus.start = 1'b0;
        checks++; if (dones !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d want=3", dones); end
        checks++; if (last !== 28) begin failures++; $display("FAIL b2b_last_done got=%0d want=28", last); end
        tick(); tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached=100000ns want=finish earlier");
        $fatal(1);
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the team's ripple adder built from half-adder cells. It trades latency for area in datapaths where a wide parallel subtractor is not justified. A start/busy/done handshake lets a controlling FSM launch one operation at a time.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range is 2 or more.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `start`  input  1  launch request; accepted only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accept edge only.
- `b`  input  WIDTH  subtrahend; sampled on the accept edge only.
- `busy`  output  1  high while in SHIFT.
- `done`  output  1  one-cycle pulse marking the result as valid.
- `diff`  output  WIDTH  result `a - b` modulo 2^WIDTH.
- `borrow_out`  output  1  final borrow; 1 exactly when unsigned `a` < unsigned `b`.
- `overflow`  output  1  signed overflow flag (see Configuration).

## Operation
- Registers:
  - operand shift registers `sa` and `sb`
  - result shift register `sd`
  - borrow flop `br`
  - bit counter sized to hold 0..WIDTH-1
  - 2-bit state
- States and transitions:
  - IDLE:
    - If `start` = 1: load `sa` <= `a`, `sb` <= `b`, `br` <= 0, counter <= 0, then go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, on each edge:
    - Full-subtractor on the LSBs: d = `sa[0]` ^ `sb[0]` ^ `br`; bo = (~`sa[0]` & `sb[0]`) | (~(`sa[0]` ^ `sb[0]`) & `br`).
    - Shift `sd` right with d entering the MSB.
    - Shift `sa` and `sb` right.
    - `br` <= bo; counter increments.
    - When counter = WIDTH-1 on this edge, go to DONE.
  - DONE: stay one cycle, then return to IDLE unconditionally.
- Outputs:
  - `diff` is `sd` driven directly. It is valid during DONE and holds its value through IDLE until the next accepted `start`.
  - `borrow_out` is `br`, with the same validity as `diff`.
- `start` is ignored in SHIFT and DONE. No queuing; a request raised while busy is dropped.
- `a` and `b` may change freely after the accept edge without affecting the result.
- The cell is purely bitwise, so any two WIDTH-bit values are legal and no input range checks exist.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - state <= IDLE
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow_out` = 0, `overflow` = 0
  - counter and all shift registers cleared
- Reset mid-SHIFT or in DONE aborts the operation. No `done` is produced and outputs take their reset values on that edge.
- Let `start` be accepted at edge E:
  - `busy` = 1 from after E until after edge E+WIDTH.
  - State is DONE after edge E+WIDTH: `done` = 1 and `busy` = 0 for exactly that one cycle.
  - State is IDLE after edge E+WIDTH+1.
- Latency is WIDTH+1 edges from accept to the result being visible at DONE.
- Minimum issue interval is WIDTH+2 cycles: the earliest next accept is edge E+WIDTH+2.
- `start` held high continuously therefore yields one operation per WIDTH+2 cycles.
- `done` and `busy` are never high simultaneously.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - A flop captures `sa[0]` and `sb[0]` at the final SHIFT edge, when they hold the operand MSBs.
  - In DONE, `overflow` = (a_msb != b_msb) & (`diff[WIDTH-1]` != a_msb).
  - `overflow` holds with `diff` and clears on reset or on the next accept.
- `SERIAL_SUB_OVF_EN` not defined:
  - The `overflow` port still exists, tied to constant 0, and no capture logic is built.

## Test plan
- WIDTH=8, a=100, b=37 -> after 9 edges `done` pulses; `diff`=63, `borrow_out`=0, `overflow`=0.
- a=5, b=9 -> `diff`=0xFC, `borrow_out`=1, `overflow`=0.
- a=0x80, b=0x01 -> `diff`=0x7F, `borrow_out`=0; `overflow`=1 with `SERIAL_SUB_OVF_EN` defined, 0 without it.
- Accept a=0x00, b=0x00; pulse `start` with a=0xFF during SHIFT -> that pulse is ignored; `diff`=0x00, `borrow_out`=0, exactly one `done`.
- `rst_n`=0 at the 4th SHIFT edge -> all outputs read 0 on the following cycle and no `done` appears.
- `start` held high for 30 cycles with a=0x10, b=0x01 -> `done` every 10 cycles, each time `diff`=0x0F, `busy` never overlaps `done`.
